// File: rtl/reg_sb_pkg.sv
// Shared constants for the register scoreboard: default address width,
// register-count derivation and busy-count width.
package reg_sb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;

  // Number of architectural registers tracked for a given address width.
  function automatic int unsigned num_regs(int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // One extra bit so the count can reach NUM_REGS without wrapping.
  function automatic int unsigned count_w(int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  localparam int unsigned NUM_REGS_DEFAULT = num_regs(ADDR_W_DEFAULT);
  localparam int unsigned COUNT_W_DEFAULT  = count_w(ADDR_W_DEFAULT);

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with enable; output is all-zero when disabled.
module onehot_decoder
  import reg_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0]           in,
  input  logic                        en,
  output logic [num_regs(ADDR_W)-1:0] onehot
);

  // Single bit set at position 'in' when enabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[in] = 1'b1;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register busy-bit scoreboard: issue marks a destination busy, writeback
// clears it, with same-cycle writeback bypass on source and issue checks.
// Optional build macro ZERO_REG_EN hardwires register 0 as never busy.
module reg_scoreboard
  import reg_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_rd,
  output logic                        issue_ready,
  input  logic                        wb_valid,
  input  logic [ADDR_W-1:0]           wb_rd,
  input  logic [ADDR_W-1:0]           rs1_addr,
  input  logic [ADDR_W-1:0]           rs2_addr,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic [num_regs(ADDR_W)-1:0] busy_vec,
  output logic [count_w(ADDR_W)-1:0]  busy_count,
  output logic                        wb_err
);

  localparam int unsigned NUM_REGS = num_regs(ADDR_W);
  localparam int unsigned COUNT_W  = count_w(ADDR_W);

`ifdef ZERO_REG_EN
  localparam logic [NUM_REGS-1:0] KEEP_MASK = ~NUM_REGS'(1);
`else
  localparam logic [NUM_REGS-1:0] KEEP_MASK = '1;
`endif

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] set_raw, clear_raw, set_onehot, clear_onehot;
  logic                fire, wb_to_zero, set_inc, clr_dec;

  assign busy_vec   = busy_q;
  assign busy_count = count_q;
  assign wb_err     = err_q;

`ifdef ZERO_REG_EN
  assign wb_to_zero = (wb_rd == '0);
`else
  assign wb_to_zero = 1'b0;
`endif

  // Issue and source checks see a same-cycle writeback as already done.
  always_comb begin
    issue_ready = !busy_q[issue_rd] || (wb_valid && (wb_rd == issue_rd));
    fire        = issue_valid && issue_ready;
    rs1_busy    = busy_q[rs1_addr] && !(wb_valid && (wb_rd == rs1_addr));
    rs2_busy    = busy_q[rs2_addr] && !(wb_valid && (wb_rd == rs2_addr));
  end

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_set_dec (
    .in     (issue_rd),
    .en     (fire),
    .onehot (set_raw)
  );

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_clear_dec (
    .in     (wb_rd),
    .en     (wb_valid),
    .onehot (clear_raw)
  );

  // Next busy state: clear then set, so a same-register set wins; the count
  // moves by at most one since only an actual 0->1 or 1->0 transition counts.
  always_comb begin
    set_onehot   = set_raw & KEEP_MASK;
    clear_onehot = clear_raw & KEEP_MASK;
    busy_d       = (busy_q & ~clear_onehot) | set_onehot;
    set_inc      = |(set_onehot & ~busy_q);
    clr_dec      = |(clear_onehot & busy_q & ~set_onehot);
    count_d      = count_q + COUNT_W'(set_inc) - COUNT_W'(clr_dec);
    err_d        = err_q || (wb_valid && !busy_q[wb_rd] && !wb_to_zero);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: the driver pushes hand-computed
// expectations, a negedge monitor pops and compares against the DUT.
module tb_reg_scoreboard;

  localparam int unsigned AW = 5;

`ifdef ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] bv;
    logic [5:0]  cnt;
    logic        err;
    logic        rdy;
    logic        b1;
    logic        b2;
  } exp_t;

  logic          clock = 1'b0;
  logic          ctrl_reset_n;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rs1_busy;
  logic          rs2_busy;
  logic [31:0]   busy_vec;
  logic [5:0]    busy_count;
  logic          wb_err;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  reg_scoreboard #(
    .ADDR_W (AW)
  ) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .busy_vec     (busy_vec),
    .busy_count   (busy_count),
    .wb_err       (wb_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "busy_vec",    busy_vec,          e.bv);
      chk(e.name, "busy_count",  32'(busy_count),   32'(e.cnt));
      chk(e.name, "wb_err",      32'(wb_err),       32'(e.err));
      chk(e.name, "issue_ready", 32'(issue_ready),  32'(e.rdy));
      chk(e.name, "rs1_busy",    32'(rs1_busy),     32'(e.b1));
      chk(e.name, "rs2_busy",    32'(rs2_busy),     32'(e.b2));
    end
  end

  task automatic drive(input logic iv, input int ird, input logic wv, input int wrd,
                       input int r1, input int r2);
    issue_valid = iv;
    issue_rd    = AW'(ird);
    wb_valid    = wv;
    wb_rd       = AW'(wrd);
    rs1_addr    = AW'(r1);
    rs2_addr    = AW'(r2);
  endtask

  task automatic expect_now(input string nm, input logic [31:0] bv, input int cnt,
                            input logic err, input logic rdy, input logic b1,
                            input logic b2);
    exp_t e;
    e.name = nm;
    e.bv   = bv;
    e.cnt  = 6'(cnt);
    e.err  = err;
    e.rdy  = rdy;
    e.b1   = b1;
    e.b2   = b2;
    exp_q.push_back(e);
  endtask

  // Drive just after a rising edge; expectations describe the state before
  // the following edge plus the combinational outputs for these inputs.
  task automatic step(input string nm, input logic iv, input int ird, input logic wv,
                      input int wrd, input int r1, input int r2, input logic [31:0] bv,
                      input int cnt, input logic err, input logic rdy, input logic b1,
                      input logic b2);
    @(posedge clock);
    #1;
    drive(iv, ird, wv, wrd, r1, r2);
    expect_now(nm, bv, cnt, err, rdy, b1, b2);
  endtask

  initial begin
    logic [31:0] full_bv;
    int          full_cnt;
    ctrl_reset_n = 1'b0;
    // Inputs asserted during reset must be ignored across the rising edge.
    drive(1'b1, 5, 1'b1, 9, 5, 0);
    expect_now("in_reset", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
    drive(1'b0, 0, 1'b0, 0, 0, 0);

    //   name            iv  ird wv  wrd r1  r2  busy_vec       cnt err  rdy  b1   b2
    step("idle_issue5",  1, 5, 0, 0, 5, 7, 32'h0000_0000, 0, 0, 1, 0, 0);
    step("busy5",        0, 5, 0, 0, 5, 0, 32'h0000_0020, 1, 0, 0, 1, 0);
    step("issue7",       1, 7, 0, 0, 5, 7, 32'h0000_0020, 1, 0, 1, 1, 0);
    step("wb5_bypass",   0, 5, 1, 5, 5, 7, 32'h0000_00A0, 2, 0, 1, 0, 1);
    step("same_reg7",    1, 7, 1, 7, 7, 5, 32'h0000_0080, 1, 0, 1, 0, 0);
    step("set3_clr7",    1, 3, 1, 7, 7, 3, 32'h0000_0080, 1, 0, 1, 0, 0);
    step("wb_err9",      0, 3, 1, 9, 3, 9, 32'h0000_0008, 1, 0, 0, 1, 0);
    step("err_sticky",   0, 9, 0, 0, 3, 9, 32'h0000_0008, 1, 1, 1, 1, 0);
    step("blocked3",     1, 3, 0, 0, 0, 0, 32'h0000_0008, 1, 1, 0, 0, 0);
    step("clear3",       0, 0, 1, 3, 3, 3, 32'h0000_0008, 1, 1, 1, 0, 0);

    // Fill every register in order; before issuing rd=i, regs 0..i-1 are busy.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] bv;
      int          cnt;
      bv  = 32'((64'd1 << i) - 64'd1);
      cnt = i;
      if (ZERO_REG) begin
        bv  = bv & 32'hFFFF_FFFE;
        cnt = (i > 0) ? i - 1 : 0;
      end
      step($sformatf("fill%0d", i), 1, i, 0, 0, i, 0, bv, cnt, 1, 1, 0,
           (i > 0) && !ZERO_REG);
    end
    full_bv  = ZERO_REG ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
    full_cnt = ZERO_REG ? 31 : 32;
    step("full", 0, 31, 0, 0, 31, 0, full_bv, full_cnt, 1, 0, 1, !ZERO_REG);

    // Asynchronous reset between edges must clear state before the next edge.
    @(posedge clock);
    #3;
    ctrl_reset_n = 1'b0;
    drive(1'b0, 31, 1'b0, 0, 31, 0);
    expect_now("async_rst", 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;

    step("issue0",       1, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 1, 0, 0);
    step("reg0_state",   0, 0, 0, 0, 0, 0, ZERO_REG ? 32'h0 : 32'h1, ZERO_REG ? 0 : 1,
         0, ZERO_REG, !ZERO_REG, !ZERO_REG);
    step("wb0",          0, 0, 1, 0, 0, 0, ZERO_REG ? 32'h0 : 32'h1, ZERO_REG ? 0 : 1,
         0, 1, 0, 0);
    step("wb0_after",    0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0);

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
